ring_nic: RTL and testbench
===========================

# ring_nic

Network interface controller between a processing element and one node of the four-node gold ring. It exposes a four-register, memory-mapped processor port: output buffer and status, input buffer and status. It also exposes a valid/ready packet port toward the ring router, with even/odd virtual-channel polarity gating on the send side. It is the responder for processor-side register traffic and the endpoint for router injection and ejection.

## Interface
- No parameters; packet width fixed at 64, address width fixed at 2.
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- addr  in  [0:1]  register select: 2'b00 input buffer, 2'b01 input status, 2'b10 output buffer, 2'b11 output status
- d_in  in  [0:63]  processor write data
- d_out  out  [0:63]  processor read data (registered)
- nicEn  in  1  processor access enable
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn)
- net_so  out  1  send valid to router
- net_ro  in  1  router ready to accept
- net_do  out  [0:63]  packet to router
- net_polarity  in  1  router cycle polarity (0 even, 1 odd)
- net_si  in  1  receive valid from router
- net_ri  out  1  NIC ready to accept from router
- net_di  in  [0:63]  packet from router
- Packet fields (bit 0 = MSB):
  - [0] vc
  - [1] dir
  - [2:7] reserved
  - [8:15] hop
  - [16:31] source
  - [32:63] payload
- The NIC never modifies packet fields.

## Operation
- State:
  - out_buf[0:63], out_full
  - in_buf[0:63], in_full
  - d_out register
- Processor write: nicEn & nicWrEn & addr==2'b10 & !out_full loads out_buf <= d_in and sets out_full.
  - Write while out_full is dropped silently.
  - Writes to 00, 01 and 11 are ignored.
- Processor read (nicEn & !nicWrEn) loads d_out at the edge:
  - 2'b00: d_out <= in_buf. If in_full, in_full clears at the same edge. A read while empty returns stale in_buf and changes no state.
  - 2'b01: d_out <= {63'b0, in_full}, with status in bit 63.
  - 2'b10: d_out <= out_buf, with no side effect.
  - 2'b11: d_out <= {63'b0, out_full}.
- When !nicEn, or on a write cycle, d_out <= 0.
- Send:
  - net_do = out_buf continuously.
  - net_so = out_full & net_ro & (out_buf[0] == net_polarity), combinational.
  - Transfer occurs at an edge where net_so=1; out_full clears at that edge.
- Receive:
  - net_ri = !in_full & !reset.
  - At an edge with net_si & net_ri: in_buf <= net_di and in_full <= 1.
  - net_si while net_ri=0 is ignored; the router must hold the packet.

## Timing
- Reset (asynchronous, immediate) sets:
  - out_buf=0, out_full=0
  - in_buf=0, in_full=0
  - d_out=0
- While reset is asserted: net_so=0, net_ri=0. After deassertion: net_ri=1, net_so=0.
- Read latency is 1 cycle: a request sampled at edge N is visible on d_out after edge N. Each read is a single-cycle access.
- Write to send:
  - A write at edge N sets out_full.
  - net_so can assert in cycle N+1 at the earliest, when polarity matches and net_ro=1.
  - The packet is gone at edge N+1.
  - A new write is accepted at edge N+2.
- Receive to status:
  - A packet captured at edge N makes an input-status read issued at edge N+1 return 1.
  - An input-buffer read consuming at edge M raises net_ri from cycle M+1.
- Simultaneous events:
  - Processor write to 2'b10 at the same edge a send completes: the write is dropped, because out_full is still 1 when sampled.
  - Input-buffer consume and net_si at the same edge: no capture, because net_ri=0 that cycle. The packet lands at the next edge if net_si is held.
  - Send and receive in the same cycle are independent.
  - Polarity mismatch stalls the send indefinitely, with no timeout.
- Reset mid-transfer: any buffered packet is lost, and the bench must not expect delivery.

## Test plan
- Reset with all inputs at 0 -> d_out=0, net_so=0, net_ri=0 during reset and 1 after; an output-status read returns 0.
- Write 64'h4001_0000_0000_0003 (vc=0) with net_ro=1 and net_polarity=1 -> net_so stays 0. Drop polarity to 0 -> net_so=1 for exactly one cycle, net_do equals the written value, then a status read returns 0.
- Write while out_full (net_ro=0) with 64'hAAAA... then 64'h5555... -> net_do stays 64'hAAAA...; a status read returns 1.
- Drive net_si=1 with net_di=64'h8000_0001_0002_0005 -> after one edge net_ri=0. Input-status read returns 64'h1. Input-buffer read returns the packet, and the next input-status read returns 0. net_ri=1 the cycle after the consume.
- Hold net_si=1 with a second packet while the first is unread -> the second is not captured until after the consume edge, and arrives intact.
- Assert reset for one cycle with both buffers full -> both statuses read 0, net_so=0, and out_buf/in_buf read 0.

Source files
------------

// File: rtl/ring_nic.sv
// ring_nic
//   Network interface between a processing element and one node of the
//   four-node gold ring. Single-entry output and input packet buffers,
//   each with a full flag, reached through a four-register processor port.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   addr         register select: 00 in_buf, 01 in status, 10 out_buf, 11 out status
//   d_in         processor write data
//   d_out        registered processor read data (zero on idle or write cycles)
//   nicEn        processor access enable
//   nicWrEn      1 = write, 0 = read (qualified by nicEn)
//   net_so       send valid toward router
//   net_ro       router ready to accept
//   net_do       packet toward router (always the output buffer)
//   net_polarity router cycle polarity (0 even, 1 odd)
//   net_si       receive valid from router
//   net_ri       NIC ready to accept from router
//   net_di       packet from router
//
// Packet bit 0 is the MSB and carries the virtual channel; the NIC never
// alters packet contents.
module ring_nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:1]  addr,
    input  logic [0:63] d_in,
    output logic [0:63] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    output logic        net_so,
    input  logic        net_ro,
    output logic [0:63] net_do,
    input  logic        net_polarity,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [0:63] net_di
);

    logic [0:63] r_out_buf;
    logic        r_out_full;
    logic [0:63] r_in_buf;
    logic        r_in_full;
    logic [0:63] r_d_out;

    logic        w_rd;
    logic        w_wr_out;
    logic        w_consume;
    logic        w_capture;
    logic        w_send;
    logic [0:63] w_rd_data;

    assign w_rd      = nicEn & ~nicWrEn;
    // A write while the output buffer is still full (including the edge at
    // which it drains) is dropped.
    assign w_wr_out  = nicEn & nicWrEn & (addr == 2'b10) & ~r_out_full;
    assign w_consume = w_rd & (addr == 2'b00) & r_in_full;

    // Only send when the packet's VC matches the current ring polarity.
    assign w_send    = r_out_full & net_ro & (r_out_buf[0] == net_polarity);
    assign net_so    = w_send;
    assign net_do    = r_out_buf;

    // Ready is low while full, so a consume and a new arrival never
    // coincide; the router holds the packet until the following edge.
    assign net_ri    = ~r_in_full & ~reset;
    assign w_capture = net_si & net_ri;

    assign d_out     = r_d_out;

    always_comb begin
        w_rd_data = '0;
        if (w_rd) begin
            case (addr)
                2'b00: w_rd_data = r_in_buf;
                2'b01: w_rd_data = {63'b0, r_in_full};
                2'b10: w_rd_data = r_out_buf;
                2'b11: w_rd_data = {63'b0, r_out_full};
                default: w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
            r_in_buf   <= '0;
            r_in_full  <= 1'b0;
            r_d_out    <= '0;
        end else begin
            r_d_out <= w_rd_data;

            if (w_send) begin
                r_out_full <= 1'b0;
            end else if (w_wr_out) begin
                r_out_buf  <= d_in;
                r_out_full <= 1'b1;
            end

            if (w_capture) begin
                r_in_buf  <= net_di;
                r_in_full <= 1'b1;
            end else if (w_consume) begin
                r_in_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_nic.sv
// tb_ring_nic
//   Directed self-checking bench for ring_nic. Inputs change 1 time unit
//   after the rising edge; outputs are sampled before the next edge.
module tb_ring_nic;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:1]  addr = '0;
    logic [0:63] d_in = '0;
    logic [0:63] d_out;
    logic        nicEn = 1'b0;
    logic        nicWrEn = 1'b0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [0:63] net_do;
    logic        net_polarity = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [0:63] net_di = '0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    localparam logic [0:63] PKT_SEND = 64'h4001_0000_0000_0003;
    localparam logic [0:63] PKT_A    = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [0:63] PKT_5    = 64'h5555_5555_5555_5555;
    localparam logic [0:63] PKT_RX1  = 64'h8000_0001_0002_0005;
    localparam logic [0:63] PKT_RX2  = 64'h0000_00C3_1234_5678;
    localparam logic [0:63] ONE      = 64'h1;
    localparam logic [0:63] ZERO     = 64'h0;

    ring_nic dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
        .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
        .net_ri(net_ri), .net_di(net_di)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [0:1] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        cyc();
        nicEn = 1'b0;
    endtask

    task automatic wr(input logic [0:1] a, input logic [0:63] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        cyc();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL rst_dout got %h exp %h", d_out, ZERO); end
        vectors++; if (net_so !== 1'b0) begin miscompares++; $display("FAIL rst_so got %b exp 0", net_so); end
        vectors++; if (net_ri !== 1'b0) begin miscompares++; $display("FAIL rst_ri got %b exp 0", net_ri); end
        cyc(); cyc();
        reset = 1'b0;
        #1;
        vectors++; if (net_ri !== 1'b1) begin miscompares++; $display("FAIL post_rst_ri got %b exp 1", net_ri); end
        vectors++; if (net_so !== 1'b0) begin miscompares++; $display("FAIL post_rst_so got %b exp 0", net_so); end
        rd(2'b11);
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL rst_outstat got %h exp %h", d_out, ZERO); end
        rd(2'b00);
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL rst_inbuf got %h exp %h", d_out, ZERO); end
        cyc();
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL idle_dout got %h exp %h", d_out, ZERO); end
    endtask

    task automatic test_send();
        net_ro = 1'b1; net_polarity = 1'b1;
        wr(2'b10, PKT_SEND);
        vectors++; if (net_so !== 1'b0) begin miscompares++; $display("FAIL send_polmis got %b exp 0", net_so); end
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL wr_dout got %h exp %h", d_out, ZERO); end
        cyc();
        vectors++; if (net_so !== 1'b0) begin miscompares++; $display("FAIL send_stall got %b exp 0", net_so); end
        net_polarity = 1'b0;
        #1;
        vectors++; if (net_so !== 1'b1) begin miscompares++; $display("FAIL send_so got %b exp 1", net_so); end
        vectors++; if (net_do !== PKT_SEND) begin miscompares++; $display("FAIL send_do got %h exp %h", net_do, PKT_SEND); end
        cyc();
        vectors++; if (net_so !== 1'b0) begin miscompares++; $display("FAIL send_once got %b exp 0", net_so); end
        rd(2'b11);
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL send_stat got %h exp %h", d_out, ZERO); end
    endtask

    task automatic test_write_full();
        net_ro = 1'b0; net_polarity = 1'b0;
        wr(2'b10, PKT_A);
        wr(2'b10, PKT_5);
        vectors++; if (net_do !== PKT_A) begin miscompares++; $display("FAIL full_do got %h exp %h", net_do, PKT_A); end
        rd(2'b11);
        vectors++; if (d_out !== ONE) begin miscompares++; $display("FAIL full_stat got %h exp %h", d_out, ONE); end
        rd(2'b10);
        vectors++; if (d_out !== PKT_A) begin miscompares++; $display("FAIL full_rdbuf got %h exp %h", d_out, PKT_A); end
        // VC of PKT_A is 1: polarity matches but router not ready
        net_polarity = 1'b1;
        #1;
        vectors++; if (net_so !== 1'b0) begin miscompares++; $display("FAIL full_noready got %b exp 0", net_so); end
        net_ro = 1'b1;
        #1;
        vectors++; if (net_so !== 1'b1) begin miscompares++; $display("FAIL full_ready got %b exp 1", net_so); end
        // Write at the same edge the send completes is dropped
        wr(2'b10, PKT_SEND);
        vectors++; if (net_so !== 1'b0) begin miscompares++; $display("FAIL drop_so got %b exp 0", net_so); end
        rd(2'b11);
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL drop_stat got %h exp %h", d_out, ZERO); end
        vectors++; if (net_do !== PKT_A) begin miscompares++; $display("FAIL drop_do got %h exp %h", net_do, PKT_A); end
        net_ro = 1'b0;
    endtask

    task automatic test_receive();
        net_si = 1'b1; net_di = PKT_RX1;
        #1;
        vectors++; if (net_ri !== 1'b1) begin miscompares++; $display("FAIL rx_ri_pre got %b exp 1", net_ri); end
        cyc();
        net_si = 1'b0; net_di = '0;
        vectors++; if (net_ri !== 1'b0) begin miscompares++; $display("FAIL rx_ri_full got %b exp 0", net_ri); end
        rd(2'b01);
        vectors++; if (d_out !== ONE) begin miscompares++; $display("FAIL rx_stat got %h exp %h", d_out, ONE); end
        rd(2'b00);
        vectors++; if (d_out !== PKT_RX1) begin miscompares++; $display("FAIL rx_data got %h exp %h", d_out, PKT_RX1); end
        vectors++; if (net_ri !== 1'b1) begin miscompares++; $display("FAIL rx_ri_after got %b exp 1", net_ri); end
        rd(2'b01);
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL rx_stat_empty got %h exp %h", d_out, ZERO); end
    endtask

    task automatic test_back_to_back();
        net_si = 1'b1; net_di = PKT_RX1;
        cyc();
        net_di = PKT_RX2;
        cyc(); cyc();
        rd(2'b00);
        vectors++; if (d_out !== PKT_RX1) begin miscompares++; $display("FAIL b2b_first got %h exp %h", d_out, PKT_RX1); end
        vectors++; if (net_ri !== 1'b1) begin miscompares++; $display("FAIL b2b_ri got %b exp 1", net_ri); end
        cyc();
        net_si = 1'b0; net_di = '0;
        vectors++; if (net_ri !== 1'b0) begin miscompares++; $display("FAIL b2b_ri_full got %b exp 0", net_ri); end
        rd(2'b00);
        vectors++; if (d_out !== PKT_RX2) begin miscompares++; $display("FAIL b2b_second got %h exp %h", d_out, PKT_RX2); end
        // Read while empty returns stale data and leaves status clear
        rd(2'b00);
        vectors++; if (d_out !== PKT_RX2) begin miscompares++; $display("FAIL stale_data got %h exp %h", d_out, PKT_RX2); end
        rd(2'b01);
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL stale_stat got %h exp %h", d_out, ZERO); end
    endtask

    task automatic test_reset_mid();
        net_ro = 1'b0; net_polarity = 1'b0;
        wr(2'b10, PKT_A);
        net_si = 1'b1; net_di = PKT_RX1;
        cyc();
        net_si = 1'b0; net_di = '0;
        rd(2'b01);
        vectors++; if (d_out !== ONE) begin miscompares++; $display("FAIL mid_instat got %h exp %h", d_out, ONE); end
        net_ro = 1'b1; net_polarity = 1'b1;
        reset = 1'b1;
        #1;
        vectors++; if (net_so !== 1'b0) begin miscompares++; $display("FAIL mid_so got %b exp 0", net_so); end
        vectors++; if (net_ri !== 1'b0) begin miscompares++; $display("FAIL mid_ri got %b exp 0", net_ri); end
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL mid_dout got %h exp %h", d_out, ZERO); end
        cyc();
        reset = 1'b0;
        net_ro = 1'b0;
        rd(2'b01);
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL mid_instat2 got %h exp %h", d_out, ZERO); end
        rd(2'b11);
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL mid_outstat got %h exp %h", d_out, ZERO); end
        rd(2'b10);
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL mid_outbuf got %h exp %h", d_out, ZERO); end
        rd(2'b00);
        vectors++; if (d_out !== ZERO) begin miscompares++; $display("FAIL mid_inbuf got %h exp %h", d_out, ZERO); end
    endtask

    initial begin
        test_reset();
        test_send();
        test_write_full();
        test_receive();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
